// File: rtl/sdsu_bus_pkg.sv
// Shared definitions for the SDSU multiply-slave bus: sequencer states,
// register map and default widths.
package sdsu_bus_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 32;

    localparam int unsigned ADDR_RESULT = 0;
    localparam int unsigned ADDR_OP_A   = 1;
    localparam int unsigned ADDR_OP_B   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWrA,
        StWrB,
        StPoll,
        StResp
    } bm_state_e;

endpackage

// File: rtl/bus_master.sv
// Sequencer for the SDSU multiply slave: write A, write B, poll for the product.
// Optional poll timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master
    import sdsu_bus_pkg::*;
#(
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [DATA_W-1:0] i_req_a,
    input  logic [DATA_W-1:0] i_req_b,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_valid,
    output logic              o_start,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_register_data,
    input  logic              i_exec,
    input  logic              i_write,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_result_data
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    bm_state_e         r_state, w_state_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [DATA_W-1:0] r_op_a, w_op_a_nxt;
    logic [DATA_W-1:0] r_op_b, w_op_b_nxt;
    logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_start, w_start_nxt;
    logic [ADDR_W-1:0] r_address, w_address_nxt;
    logic [DATA_W-1:0] r_register_data, w_register_data_nxt;
    logic              w_hold_last;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic             r_rsp_err, w_rsp_err_nxt;
`endif

    // Slave status is observation-only; parameter kept for a uniform interface.
    logic [1:0] w_unused;
    assign w_unused = {i_exec, TIMEOUT_CYCLES[0]};

    assign w_hold_last = (r_hold == HOLD_W'(HOLD_CYCLES - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_op_a_nxt     = r_op_a;
        w_op_b_nxt     = r_op_b;
        w_rsp_data_nxt = r_rsp_data;
`ifdef BUS_MASTER_TIMEOUT_EN
        w_tmo_nxt      = '0;
        w_rsp_err_nxt  = r_rsp_err;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_req_valid && r_req_ready) begin
                    w_state_nxt = StWrA;
                    w_hold_nxt  = '0;
                    w_op_a_nxt  = i_req_a;
                    w_op_b_nxt  = i_req_b;
                end
            end
            StWrA: begin
                if (w_hold_last) begin
                    w_state_nxt = StWrB;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            StWrB: begin
                if (w_hold_last) begin
                    w_state_nxt = StPoll;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            StPoll: begin
                if (i_ready && i_write) begin
                    w_state_nxt    = StResp;
                    w_rsp_data_nxt = i_result_data;
`ifdef BUS_MASTER_TIMEOUT_EN
                    w_rsp_err_nxt  = 1'b0;
                end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt    = StResp;
                    w_rsp_data_nxt = '0;
                    w_rsp_err_nxt  = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
`endif
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // Response fields only carry meaning while the response is offered.
        if (w_state_nxt != StResp) begin
            w_rsp_data_nxt = '0;
`ifdef BUS_MASTER_TIMEOUT_EN
            w_rsp_err_nxt  = 1'b0;
`endif
        end
    end

    // Moore outputs registered from the next state so they track it exactly.
    always_comb begin
        w_req_ready_nxt     = (w_state_nxt == StIdle);
        w_rsp_valid_nxt     = (w_state_nxt == StResp);
        w_valid_nxt         = (w_state_nxt == StWrA) || (w_state_nxt == StWrB);
        w_start_nxt         = (w_state_nxt == StPoll);
        w_address_nxt       = ADDR_W'(ADDR_RESULT);
        w_register_data_nxt = '0;
        if (w_state_nxt == StWrA) begin
            w_address_nxt       = ADDR_W'(ADDR_OP_A);
            w_register_data_nxt = w_op_a_nxt;
        end else if (w_state_nxt == StWrB) begin
            w_address_nxt       = ADDR_W'(ADDR_OP_B);
            w_register_data_nxt = w_op_b_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_hold          <= '0;
            r_op_a          <= '0;
            r_op_b          <= '0;
            r_rsp_data      <= '0;
            r_req_ready     <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_valid         <= 1'b0;
            r_start         <= 1'b0;
            r_address       <= '0;
            r_register_data <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
            r_tmo           <= '0;
            r_rsp_err       <= 1'b0;
`endif
        end else begin
            r_state         <= w_state_nxt;
            r_hold          <= w_hold_nxt;
            r_op_a          <= w_op_a_nxt;
            r_op_b          <= w_op_b_nxt;
            r_rsp_data      <= w_rsp_data_nxt;
            r_req_ready     <= w_req_ready_nxt;
            r_rsp_valid     <= w_rsp_valid_nxt;
            r_valid         <= w_valid_nxt;
            r_start         <= w_start_nxt;
            r_address       <= w_address_nxt;
            r_register_data <= w_register_data_nxt;
`ifdef BUS_MASTER_TIMEOUT_EN
            r_tmo           <= w_tmo_nxt;
            r_rsp_err       <= w_rsp_err_nxt;
`endif
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_data      = r_rsp_data;
    assign o_valid         = r_valid;
    assign o_start         = r_start;
    assign o_address       = r_address;
    assign o_register_data = r_register_data;
`ifdef BUS_MASTER_TIMEOUT_EN
    assign o_rsp_err       = r_rsp_err;
`else
    assign o_rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: behavioural multiply slave plus a per-cycle expected bus
// trace built from the transaction's phase lengths.
module tb_bus_master;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int H   = 2;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] req_a, req_b, rsp_data, register_data, s_result;
    logic          bus_valid, bus_start, s_exec, s_write, s_ready;
    logic [AW-1:0] bus_address;

    always #5 clk = ~clk;

    bus_master #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .HOLD_CYCLES   (H),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_err      (rsp_err),
        .o_valid        (bus_valid),
        .o_start        (bus_start),
        .o_address      (bus_address),
        .o_register_data(register_data),
        .i_exec         (s_exec),
        .i_write        (s_write),
        .i_ready        (s_ready),
        .i_result_data  (s_result)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [95:0] mk(input bit rr, input bit rv, input bit v, input bit s,
                                       input logic [31:0] ad, input logic [31:0] d);
        return {28'b0, rr, rv, v, s, ad, d};
    endfunction

    function automatic logic [95:0] bus_now();
        return {28'b0, req_ready, rsp_valid, bus_valid, bus_start, bus_address, register_data};
    endfunction

    // Behavioural slave: latches operands off the bus, answers after slave_delay
    // polling cycles, and throws noise on ready/write whenever it must be ignored.
    int            slave_delay = 0;
    int            poll_cnt    = 0;
    logic [DW-1:0] sa = '0, sb = '0;

    always @(negedge clk) begin
        if (bus_valid && bus_address == 1) sa = register_data;
        if (bus_valid && bus_address == 2) sb = register_data;
        s_exec = 1'($urandom_range(0, 1));
        if (bus_start) begin
            if (poll_cnt >= slave_delay) begin
                s_ready  = 1'b1;
                s_write  = 1'b1;
                s_result = sa * sb;
            end else begin
                s_ready  = 1'($urandom_range(0, 1));
                s_write  = ~s_ready;
                s_result = $urandom;
            end
            poll_cnt++;
        end else begin
            poll_cnt = 0;
            s_ready  = 1'($urandom_range(0, 1));
            s_write  = 1'($urandom_range(0, 1));
            s_result = $urandom;
        end
    end

    task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int d, input int bp, input bit tmo);
        logic [63:0] full;
        logic [31:0] exp_data;
        logic [95:0] exp_rsp;
        int          k_rsp;
        full        = 64'(a) * 64'(b);
        exp_data    = tmo ? 32'h0 : full[31:0];
        slave_delay = tmo ? 100000 : d;
        k_rsp       = 2 * H + 2 + (tmo ? TMO - 1 : d);
        exp_rsp     = {28'b0, 1'b0, 1'b1, 1'b0, 1'b0, 31'b0, tmo, exp_data};
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        for (int k = 1; k < k_rsp; k++) begin
            logic [95:0] exp;
            if (k <= H)          exp = mk(0, 0, 1, 0, 32'd1, a);
            else if (k <= 2 * H) exp = mk(0, 0, 1, 0, 32'd2, b);
            else                 exp = mk(0, 0, 0, 1, 32'd0, 32'd0);
            check_eq($sformatf("%s_bus_c%0d", name, k), bus_now(), exp);
            @(negedge clk);
        end
        check_eq({name, "_rsp"},
                 {28'b0, req_ready, rsp_valid, bus_valid, bus_start, 31'b0, rsp_err, rsp_data},
                 exp_rsp);
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            req_a     = $urandom;
            req_b     = $urandom;
            @(negedge clk);
            check_eq($sformatf("%s_bp%0d", name, i),
                     {28'b0, req_ready, rsp_valid, bus_valid, bus_start, 31'b0, rsp_err,
                      rsp_data}, exp_rsp);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({name, "_done"}, bus_now(), mk(1, 0, 0, 0, 32'd0, 32'd0));
    endtask

    task automatic reset_mid();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (H) @(negedge clk);
        check_eq("rmid_in_wrb", bus_now(), mk(0, 0, 1, 0, 32'd2, b));
        rst = 1'b1;
        @(negedge clk);
        check_eq("rmid_reset", bus_now(), mk(0, 0, 0, 0, 32'd0, 32'd0));
        check_eq("rmid_reset_rsp", {63'b0, rsp_err, rsp_data}, 96'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rmid_ready", bus_now(), mk(1, 0, 0, 0, 32'd0, 32'd0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("rmid_dropped%0d", i), bus_now(), mk(1, 0, 0, 0, 32'd0, 32'd0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_bus", bus_now(), mk(0, 0, 0, 0, 32'd0, 32'd0));
        check_eq("reset_rsp", {63'b0, rsp_err, rsp_data}, 96'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", bus_now(), mk(1, 0, 0, 0, 32'd0, 32'd0));

        run_txn("basic", 32'd6, 32'd7, 0, 0, 1'b0);
        run_txn("backpressure", $urandom, $urandom, 0, 10, 1'b0);
        run_txn("slow", $urandom, $urandom, 20, 1, 1'b0);
        reset_mid();
        run_txn("b2b_1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_txn("b2b_2", 32'd3, 32'd5, 0, 0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_txn($sformatf("rand%0d", t), $urandom, $urandom, $urandom_range(0, 6),
                    $urandom_range(0, 3), 1'b0);
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        run_txn("timeout", $urandom, $urandom, 0, 2, 1'b1);
        run_txn("after_tmo", 32'd9, 32'd11, 1, 0, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
